rpn_stack_ctrl: RTL and testbench

- Command sequencer that drives the calculator's operand stack through its push/pop/write port and consumes its top/next/count/error outputs.
- Accepts one RPN command at a time: enter a number, arithmetic, or a stack manipulation.
- Converts each command into a fixed sequence of single-cycle stack strobes, then reports completion and error to the calculator front end.

---
 rtl/rpn_stack_ctrl.sv | 169 ++++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_ctrl.sv
// RPN command sequencer: turns one calculator command into a
// short run of single-cycle push/pop/write strobes on the operand stack.
module rpn_stack_ctrl #(
  parameter int WIDTH     = 32,
  parameter int COUNT_W   = 6,
  parameter int MAX_DEPTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_value,
  input  logic [WIDTH-1:0]   stk_top,
  input  logic [WIDTH-1:0]   stk_next,
  input  logic [COUNT_W-1:0] stk_count,
  input  logic               stk_error,
  output logic               stk_push,
  output logic               stk_pop,
  output logic               stk_write,
  output logic [WIDTH-1:0]   stk_value,
  output logic               done,
  output logic               error
);

  localparam logic [2:0] OP_ENTER = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_NEG   = 3'd4;
  localparam logic [2:0] OP_DROP  = 3'd5;
  localparam logic [2:0] OP_DUP   = 3'd6;
  localparam logic [2:0] OP_SWAP  = 3'd7;

  localparam logic [COUNT_W-1:0] FULL = COUNT_W'(MAX_DEPTH);
  localparam logic [COUNT_W-1:0] TWO  = COUNT_W'(2);

  typedef enum logic [3:0] {
    IDLE,
    EN_PUSH,
    EN_WR,
    AR_POP,
    AR_WR,
    NEG_WR,
    DROP_POP,
    DUP_PUSH,
    SW_POP,
    SW_WR_T,
    SW_PUSH,
    SW_WR_N,
    DONE
  } state_e;

  state_e             state_q, state_d;
  state_e             first;
  logic [WIDTH-1:0]   t_q, t_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [WIDTH-1:0]   v_q, v_d;
  logic [2:0]         op_q, op_d;
  logic               ill_q, ill_d;
  logic               legal;

  always_comb begin
    legal = 1'b0;
    first = IDLE;
    unique case (cmd_op)
      OP_ENTER: begin
        legal = stk_count < FULL;
        first = EN_PUSH;
      end
      OP_ADD, OP_SUB, OP_MUL: begin
        legal = stk_count >= TWO;
        first = AR_POP;
      end
      OP_NEG: begin
        legal = stk_count != '0;
        first = NEG_WR;
      end
      OP_DROP: begin
        legal = stk_count != '0;
        first = DROP_POP;
      end
      OP_DUP: begin
        legal = stk_count < FULL;
        first = DUP_PUSH;
      end
      OP_SWAP: begin
        legal = stk_count >= TWO;
        first = SW_POP;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    n_d     = n_q;
    v_d     = v_q;
    op_d    = op_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          t_d     = stk_top;
          n_d     = stk_next;
          v_d     = cmd_value;
          op_d    = cmd_op;
          ill_d   = !legal;
          state_d = legal ? first : DONE;
        end
      end
      EN_PUSH: state_d = EN_WR;
      AR_POP:  state_d = AR_WR;
      SW_POP:  state_d = SW_WR_T;
      SW_WR_T: state_d = SW_PUSH;
      SW_PUSH: state_d = SW_WR_N;
      EN_WR, AR_WR, NEG_WR, DROP_POP, DUP_PUSH, SW_WR_N:
        state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      n_q     <= '0;
      v_q     <= '0;
      op_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      n_q     <= n_d;
      v_q     <= v_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
    end
  end

  // Strobes come straight off the state register; reset forces IDLE.
  assign cmd_ready = (state_q == IDLE) && !reset;
  assign stk_push  = state_q inside {EN_PUSH, DUP_PUSH, SW_PUSH};
  assign stk_pop   = state_q inside {AR_POP, DROP_POP, SW_POP};
  assign stk_write = state_q inside {EN_WR, AR_WR, NEG_WR,
                                     SW_WR_T, SW_WR_N};
  assign done      = state_q == DONE;
  assign error     = done && (ill_q || stk_error);

  always_comb begin
    stk_value = '0;
    unique case (state_q)
      EN_WR:   stk_value = v_q;
      NEG_WR:  stk_value = -t_q;
      SW_WR_T: stk_value = t_q;
      SW_WR_N: stk_value = n_q;
      AR_WR: begin
        unique case (op_q)
          OP_ADD:  stk_value = n_q + t_q;
          OP_SUB:  stk_value = n_q - t_q;
          default: stk_value = n_q * t_q;
        endcase
      end
      default: stk_value = '0;
    endcase
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Scoreboard bench for rpn_stack_ctrl driving a behavioural operand stack.
module tb_rpn_stack_ctrl;

  localparam logic [7:0] TR_EN   = 8'h07;
  localparam logic [7:0] TR_AR   = 8'h0B;
  localparam logic [7:0] TR_NEG  = 8'h03;
  localparam logic [7:0] TR_DROP = 8'h02;
  localparam logic [7:0] TR_DUP  = 8'h01;
  localparam logic [7:0] TR_SWAP = 8'hB7;

  localparam logic [2:0] ENTER = 3'd0, ADD = 3'd1, SUB = 3'd2;
  localparam logic [2:0] MUL = 3'd3, NEG = 3'd4, DROP = 3'd5;
  localparam logic [2:0] DUP = 3'd6, SWAP = 3'd7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_value = '0;
  logic [31:0] stk_top, stk_next;
  logic [5:0]  stk_count;
  logic        stk_error;
  logic        stk_push, stk_pop, stk_write;
  logic [31:0] stk_value;
  logic        done, error;

  int checks = 0;
  int errors = 0;

  rpn_stack_ctrl dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_value(cmd_value),
    .stk_top(stk_top), .stk_next(stk_next),
    .stk_count(stk_count), .stk_error(stk_error),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_write(stk_write), .stk_value(stk_value),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Behavioural operand stack reacting to the strobes.
  logic [31:0] mem [0:31];
  int   cnt_m = 0;
  logic err_m = 1'b0;

  always @(posedge clock) begin
    if (stk_push) begin
      if (cnt_m >= 32) err_m <= 1'b1;
      else begin
        mem[cnt_m] <= (cnt_m > 0) ? mem[cnt_m-1] : 32'd0;
        cnt_m <= cnt_m + 1;
      end
    end else if (stk_pop) begin
      if (cnt_m == 0) err_m <= 1'b1;
      else cnt_m <= cnt_m - 1;
    end else if (stk_write) begin
      if (cnt_m > 0) mem[cnt_m-1] <= stk_value;
    end
  end

  always_comb begin
    stk_top   = (cnt_m > 0) ? mem[cnt_m-1] : 32'd0;
    stk_next  = (cnt_m > 1) ? mem[cnt_m-2] : 32'd0;
    stk_count = 6'(cnt_m);
    stk_error = err_m;
  end

  typedef struct {
    string       nm;
    logic        err;
    int          lat;
    int          ns;
    logic [7:0]  tr;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] top;
    int          cnt;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input string what,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  // Monitor: trace strobes per command, compare on each done pulse.
  logic        armed = 1'b0;
  int          lat_c = 0, ns_c = 0, nw_c = 0;
  logic [7:0]  tr_c = '0;
  logic [31:0] wv0 = '0, wv1 = '0;

  always @(negedge clock) begin
    if (reset) begin
      armed = 1'b0;
    end else begin
      chk("cycle", "strobe_excl",
          64'(((32'(stk_push) + 32'(stk_pop) + 32'(stk_write)) > 1)
              || (!stk_write && stk_value != 0)
              || (done && (stk_push || stk_pop || stk_write))), 0);
      if (armed) lat_c++;
      if (stk_push || stk_pop || stk_write) begin
        tr_c = {tr_c[5:0], stk_push ? 2'd1 : stk_pop ? 2'd2 : 2'd3};
        ns_c++;
        if (stk_write) begin
          if (nw_c == 0) wv0 = stk_value;
          else wv1 = stk_value;
          nw_c++;
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("done", "unexpected", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk(e.nm, "error", 64'(error), 64'(e.err));
          chk(e.nm, "latency", 64'(lat_c), 64'(e.lat));
          chk(e.nm, "strobes", 64'(ns_c), 64'(e.ns));
          chk(e.nm, "order", 64'(tr_c), 64'(e.tr));
          chk(e.nm, "writes", 64'(nw_c), 64'(e.nw));
          if (e.nw >= 1) chk(e.nm, "wval0", 64'(wv0), 64'(e.w0));
          if (e.nw >= 2) chk(e.nm, "wval1", 64'(wv1), 64'(e.w1));
          chk(e.nm, "top", 64'(stk_top), 64'(e.top));
          chk(e.nm, "count", 64'(cnt_m), 64'(e.cnt));
          chk(e.nm, "stk_err", 64'(err_m), 0);
        end
        armed = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        armed = 1'b1;
        lat_c = 0;
        ns_c  = 0;
        nw_c  = 0;
        tr_c  = '0;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] val,
                      input string nm);
    bit ok;
    ok = 0;
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_value = val;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (cmd_ready) ok = 1;
    end
    if (ok) @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_value = $urandom;
    chk(nm, "accepted", 64'(ok), 1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] val,
                       input string nm, input logic err, input int lat,
                       input int ns, input logic [7:0] tr, input int nw,
                       input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] top, input int cnt);
    exp_t e;
    e.nm = nm; e.err = err; e.lat = lat; e.ns = ns; e.tr = tr;
    e.nw = nw; e.w0 = w0; e.w1 = w1; e.top = top; e.cnt = cnt;
    q.push_back(e);
    send(op, val, nm);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
    chk("drain", "pending", 64'(q.size()), 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, "ready", 64'(cmd_ready), 0);
    chk(tag, "strobes", 64'({stk_push, stk_pop, stk_write}), 0);
    chk(tag, "value", 64'(stk_value), 0);
    chk(tag, "done_err", 64'({done, error}), 0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clock);
    chk_quiet("reset");
    reset = 1'b0;

    issue(ENTER, 5, "enter5", 0, 3, 2, TR_EN, 1, 5, 0, 5, 1);
    issue(ENTER, 7, "enter7", 0, 3, 2, TR_EN, 1, 7, 0, 7, 2);
    issue(ADD, 0, "add", 0, 3, 2, TR_AR, 1, 12, 0, 12, 1);
    issue(DROP, 0, "drop", 0, 2, 1, TR_DROP, 0, 0, 0, 0, 0);
    issue(ADD, 0, "add_empty", 1, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    issue(DROP, 0, "drop_empty", 1, 1, 0, 8'h00, 0, 0, 0, 0, 0);

    issue(ENTER, 3, "enter3", 0, 3, 2, TR_EN, 1, 3, 0, 3, 1);
    issue(ENTER, 10, "enter10", 0, 3, 2, TR_EN, 1, 10, 0, 10, 2);
    issue(SUB, 0, "sub", 0, 3, 2, TR_AR, 1,
          32'hFFFFFFF9, 0, 32'hFFFFFFF9, 1);
    issue(ENTER, 3, "enter3b", 0, 3, 2, TR_EN, 1, 3, 0, 3, 2);
    issue(ENTER, 10, "enter10b", 0, 3, 2, TR_EN, 1, 10, 0, 10, 3);
    issue(SWAP, 0, "swap", 0, 5, 4, TR_SWAP, 2, 10, 3, 3, 3);
    issue(SUB, 0, "sub_swapped", 0, 3, 2, TR_AR, 1, 7, 0, 7, 2);
    issue(DROP, 0, "drop7", 0, 2, 1, TR_DROP, 0, 0, 0,
          32'hFFFFFFF9, 1);
    issue(DROP, 0, "drop_m7", 0, 2, 1, TR_DROP, 0, 0, 0, 0, 0);

    issue(ENTER, 32'h10000, "enter_big", 0, 3, 2, TR_EN, 1,
          32'h10000, 0, 32'h10000, 1);
    issue(ENTER, 32'h10000, "enter_big2", 0, 3, 2, TR_EN, 1,
          32'h10000, 0, 32'h10000, 2);
    issue(MUL, 0, "mul_trunc", 0, 3, 2, TR_AR, 1, 0, 0, 0, 1);
    issue(DROP, 0, "drop_mul", 0, 2, 1, TR_DROP, 0, 0, 0, 0, 0);

    issue(ENTER, 1, "enter1", 0, 3, 2, TR_EN, 1, 1, 0, 1, 1);
    issue(NEG, 0, "neg1", 0, 2, 1, TR_NEG, 1,
          32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1);
    issue(NEG, 0, "neg_back", 0, 2, 1, TR_NEG, 1, 1, 0, 1, 1);
    issue(DUP, 0, "dup", 0, 2, 1, TR_DUP, 0, 0, 0, 1, 2);
    issue(DROP, 0, "drop_dup", 0, 2, 1, TR_DROP, 0, 0, 0, 1, 1);

    for (int i = 0; i < 31; i++)
      issue(ENTER, 32'(100 + i), "fill", 0, 3, 2, TR_EN, 1,
            32'(100 + i), 0, 32'(100 + i), 2 + i);
    issue(ENTER, 99, "enter_full", 1, 1, 0, 8'h00, 0, 0, 0, 130, 32);
    issue(DUP, 0, "dup_full", 1, 1, 0, 8'h00, 0, 0, 0, 130, 32);
    drain();

    // Abort a SWAP just after its POP step.
    send(SWAP, 0, "swap_abort");
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (stk_pop) seen = 1;
    end
    chk("swap_abort", "pop_seen", 64'(seen), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk_quiet("mid_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_reset", "ready", 64'(cmd_ready), 1);
    repeat (3) begin
      @(negedge clock);
      chk("post_reset", "idle_out",
          64'({stk_push, stk_pop, stk_write, done}), 0);
    end
    chk("post_reset", "count", 64'(cnt_m), 31);
    chk("post_reset", "top", 64'(stk_top), 129);
    issue(ENTER, 77, "enter_after", 0, 3, 2, TR_EN, 1, 77, 0, 77, 32);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
